// File: rtl/flash_pkg.sv
// Shared definitions for the flash burst reader.
// Holds the controller state encoding and the default timing constants
// used when integrating the reader into a loader.
package flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CE_WAIT,
        OE_WAIT,
        CAPTURE,
        RECOVER
    } state_t;

    localparam int TCE_DEF  = 5;
    localparam int TOE_DEF  = 6;
    localparam int TREC_DEF = 2;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear and count enable.
// Ports:
//   clk, n_rst    clock, asynchronous active-low reset
//   clear         synchronous clear to 0 (wins over count_enable)
//   count_enable  increment by one when high
//   count_out     current count, wraps at 2^NUM_CNT_BITS
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            count_out <= count_out + 1'b1;
        end
    end

endmodule

// File: rtl/flash_burst_reader.sv
// Burst reader for an asynchronous parallel NOR flash.
// Fetches burst_len+1 consecutive words starting at start_addr, using
// programmable CE-to-OE (tce) and OE/address-to-data (toe) delays.
// Ports:
//   clk, n_rst         clock, asynchronous active-low reset
//   req, abort         start request (IDLE only) / terminate the burst
//   start_addr, burst_len, tce, toe   burst parameters, latched on accept
//   busy               high whenever not IDLE
//   rdata, rdata_valid last captured word and its one-cycle strobe
//   done, aborted      end-of-burst pulse; aborted flags an abort-ended burst
//   flash_addr, flash_data, ce_n, oe_n, we_n   flash pins
//
// state    | meaning
// IDLE     | waiting for req
// SETUP    | address driven, chip still deselected
// CE_WAIT  | ce_n low, waiting max(tce,1) cycles
// OE_WAIT  | ce_n/oe_n low, waiting max(toe,1) cycles for data
// CAPTURE  | sample flash_data, step to next word or finish
// RECOVER  | chip deselected for TREC cycles
module flash_burst_reader
    import flash_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 4,
    parameter int BL_W   = 4,
    parameter int TREC   = TREC_DEF
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [BL_W-1:0]   burst_len,
    input  logic [CNT_W-1:0]  tce,
    input  logic [CNT_W-1:0]  toe,
    output logic              busy,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W-1:0] flash_addr,
    input  logic [DATA_W-1:0] flash_data,
    output logic              ce_n,
    output logic              oe_n,
    output logic              we_n
);

    localparam logic [CNT_W-1:0] TREC_LAST = CNT_W'(TREC - 1);

    state_t            state, next_state;
    logic [BL_W-1:0]   word_cnt;
    logic [CNT_W-1:0]  tce_q, toe_q, wait_cnt;
    logic [CNT_W-1:0]  tce_lim, toe_lim;
    logic              accept, abort_hit, step_word, done_pre;
    logic              cnt_clear, cnt_en;
    logic              abort_pend, done_d, ab_d;

    // A programmed delay of 0 is treated as 1 cycle.
    assign tce_lim = (tce_q == '0) ? '0 : tce_q - 1'b1;
    assign toe_lim = (toe_q == '0) ? '0 : toe_q - 1'b1;
    assign we_n    = 1'b1;

    flex_counter #(.NUM_CNT_BITS(CNT_W)) u_wait_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (cnt_en),
        .count_out    (wait_cnt)
    );

    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        accept     = (state == IDLE) && req;
        abort_hit  = abort && (state inside {SETUP, CE_WAIT, OE_WAIT, CAPTURE});
        cnt_en     = (state inside {CE_WAIT, OE_WAIT, RECOVER});
        case (state)
            IDLE:    if (req) next_state = SETUP;
            SETUP:   next_state = CE_WAIT;
            CE_WAIT: if (wait_cnt == tce_lim) next_state = OE_WAIT;
            OE_WAIT: if (wait_cnt == toe_lim) next_state = CAPTURE;
            CAPTURE: next_state = (word_cnt == '0) ? RECOVER : OE_WAIT;
            RECOVER: if (wait_cnt == TREC_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort_hit) next_state = RECOVER;
        // Every state entry (including CAPTURE -> OE_WAIT) restarts the wait count.
        cnt_clear  = (next_state != state);
        step_word  = (state == CAPTURE) && (next_state == OE_WAIT);
        done_pre   = (state == RECOVER) && (next_state == IDLE);
    end

    // Chip controls and done are registered from the current state, so the
    // pins lag the state by one cycle and never glitch on decode.
    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            flash_addr  <= '0;
            word_cnt    <= '0;
            tce_q       <= '0;
            toe_q       <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            ce_n        <= 1'b1;
            oe_n        <= 1'b1;
            abort_pend  <= 1'b0;
            done_d      <= 1'b0;
            ab_d        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            if (accept) begin
                flash_addr <= start_addr;
                word_cnt   <= burst_len;
                tce_q      <= tce;
                toe_q      <= toe;
            end else if (step_word) begin
                flash_addr <= flash_addr + 1'b1;
                word_cnt   <= word_cnt - 1'b1;
            end
            if (state == CAPTURE) rdata <= flash_data;
            rdata_valid <= (state == CAPTURE);
            ce_n        <= !(state inside {CE_WAIT, OE_WAIT, CAPTURE});
            oe_n        <= !(state inside {OE_WAIT, CAPTURE});
            if (accept) begin
                abort_pend <= 1'b0;
            end else if (abort_hit) begin
                abort_pend <= 1'b1;
            end
            done_d <= done_pre;
            ab_d   <= done_pre && abort_pend;
            done   <= done_d;
            if (done_d) begin
                aborted <= ab_d;
            end else if (accept) begin
                aborted <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_flash_burst_reader.sv
module tb_flash_burst_reader;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;
    localparam int BL_W   = 4;
    localparam int TREC   = 2;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              req, abort;
    logic [ADDR_W-1:0] start_addr;
    logic [BL_W-1:0]   burst_len;
    logic [CNT_W-1:0]  tce, toe;
    logic              busy, rdata_valid, done, aborted;
    logic [DATA_W-1:0] rdata, flash_data;
    logic [ADDR_W-1:0] flash_addr;
    logic              ce_n, oe_n, we_n;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    flash_burst_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .BL_W(BL_W), .TREC(TREC)
    ) dut (
        .clk(clk), .n_rst(n_rst), .req(req), .abort(abort),
        .start_addr(start_addr), .burst_len(burst_len), .tce(tce), .toe(toe),
        .busy(busy), .rdata(rdata), .rdata_valid(rdata_valid), .done(done),
        .aborted(aborted), .flash_addr(flash_addr), .flash_data(flash_data),
        .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Flash contents: a fixed word at 0x0100, a byte-swap scramble elsewhere.
    function automatic logic [15:0] fdata(input logic [15:0] a);
        if (a == 16'h0100) return 16'hBEEF;
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction
    assign flash_data = fdata(flash_addr);

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one burst starting at the current negedge. Expected pin behaviour
    // is derived from edge offsets relative to the accepting edge (offset 0):
    // captures at T+2+k*(toe+1), pins lag state by one cycle, done at
    // (entry to recovery)+TREC+1. abort_off/busy_req_off < 0 disable those.
    // Returns at the negedge of the expected done cycle.
    task automatic run_burst(input string tag, input logic [15:0] sa, input int bl,
                             input int tce_v, input int toe_v, input int abort_off,
                             input int busy_req_off, output int first_off,
                             output int done_off, output int words);
        int te, to, tt, last_cap, ez, done_exp, pin_err, bad_off, ninc, e0, c;
        logic is_ab, exp_ce, exp_oe, exp_busy, exp_valid, exp_done, exp_ab;
        logic [15:0] exp_addr, a_k;
        int cap[$];
        te = (tce_v == 0) ? 1 : tce_v;
        to = (toe_v == 0) ? 1 : toe_v;
        tt = te + to;
        last_cap = tt + 2 + bl * (to + 1);
        is_ab = (abort_off >= 0) && (abort_off + 1 <= last_cap);
        ez = is_ab ? abort_off + 1 : last_cap;
        for (int k = 0; k <= bl; k++) begin
            c = tt + 2 + k * (to + 1);
            if (c <= ez) cap.push_back(c);
        end
        done_exp = ez + TREC + 1;

        start_addr = sa;
        burst_len  = BL_W'(bl);
        tce        = CNT_W'(tce_v);
        toe        = CNT_W'(toe_v);
        req        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        e0 = cyc;
        req = 1'b0;
        start_addr = 16'($urandom);
        burst_len  = BL_W'($urandom);
        tce        = CNT_W'($urandom);
        toe        = CNT_W'($urandom);

        first_off = -1;
        done_off  = -1;
        words     = 0;
        pin_err   = 0;
        bad_off   = -1;
        for (int off = 0; off <= done_exp; off++) begin
            if (off > 0) @(negedge clk);
            check_int({tag, " cycle"}, cyc - e0, off);
            exp_ce    = !(off >= 2 && off <= ez);
            exp_oe    = !(off >= 2 + te && off <= ez);
            exp_busy  = (off < ez + TREC);
            exp_done  = (off == done_exp);
            exp_ab    = is_ab && (off >= done_exp);
            exp_valid = 1'b0;
            ninc      = 0;
            foreach (cap[k]) begin
                if (cap[k] == off) exp_valid = 1'b1;
                if (cap[k] <= off && cap[k] < ez) ninc++;
            end
            exp_addr = sa + 16'(ninc);
            if (ce_n !== exp_ce || oe_n !== exp_oe || we_n !== 1'b1 ||
                busy !== exp_busy || flash_addr !== exp_addr ||
                rdata_valid !== exp_valid || done !== exp_done || aborted !== exp_ab) begin
                pin_err++;
                if (bad_off < 0) bad_off = off;
            end
            if (rdata_valid === 1'b1) begin
                a_k = sa + 16'(words);
                check_int({tag, " rdata"}, int'(rdata), int'(fdata(a_k)));
                words++;
                if (first_off < 0) first_off = off;
            end
            if (done === 1'b1 && done_off < 0) done_off = off;
            abort = (off == abort_off);
            req   = (off == busy_req_off);
        end
        abort = 1'b0;
        req   = 1'b0;
        check_int({tag, " pin deviations"}, pin_err, 0);
        if (pin_err != 0) $display("  %s: first pin deviation at offset %0d", tag, bad_off);
        check_int({tag, " words"}, words, cap.size());
        check_int({tag, " first valid"}, first_off, (cap.size() > 0) ? cap[0] : -1);
        check_int({tag, " done offset"}, done_off, done_exp);
    endtask

    typedef struct {
        logic [15:0] sa;
        int bl;
        int tce;
        int toe;
        int exp_first;
        int exp_done;
        int exp_words;
    } vec_t;

    vec_t vecs[6];
    int   fo, dof, nw;

    initial begin
        // Hand-derived: first = max(tce,1)+max(toe,1)+2,
        // last capture = first + bl*(max(toe,1)+1), done = last + TREC + 1.
        vecs[0] = '{16'h0100, 0,  5,  6, 13, 16,  1};
        vecs[1] = '{16'h0010, 3,  2,  3,  7, 22,  4};
        vecs[2] = '{16'hFFFE, 3,  1,  2,  5, 17,  4};
        vecs[3] = '{16'h1234, 2,  0,  0,  4, 11,  3};
        vecs[4] = '{16'h8000, 1, 15, 15, 32, 51,  2};
        vecs[5] = '{16'h0000, 15, 1,  1,  4, 37, 16};

        n_rst = 1'b1;
        req = 1'b0;
        abort = 1'b0;
        start_addr = '0;
        burst_len = '0;
        tce = '0;
        toe = '0;
        #1 n_rst = 1'b0;
        #1;
        check_int("reset ce_n", int'(ce_n), 1);
        check_int("reset oe_n", int'(oe_n), 1);
        check_int("reset we_n", int'(we_n), 1);
        check_int("reset busy", int'(busy), 0);
        check_int("reset flash_addr", int'(flash_addr), 0);
        check_int("reset rdata", int'(rdata), 0);
        check_int("reset outputs", int'({rdata_valid, done, aborted}), 0);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_burst($sformatf("vec%0d", i), vecs[i].sa, vecs[i].bl, vecs[i].tce,
                      vecs[i].toe, -1, -1, fo, dof, nw);
            check_int($sformatf("vec%0d table first", i), fo, vecs[i].exp_first);
            check_int($sformatf("vec%0d table done", i), dof, vecs[i].exp_done);
            check_int($sformatf("vec%0d table words", i), nw, vecs[i].exp_words);
            @(negedge clk);
            @(negedge clk);
        end

        // Abort during the second OE_WAIT of a 4-word burst, with a stray req
        // while busy: one word, done+aborted at offset 9+TREC+1.
        run_burst("abort", 16'h0200, 3, 2, 3, 8, 3, fo, dof, nw);
        check_int("abort words", nw, 1);
        check_int("abort done", dof, 12);
        check_int("abort aborted flag", int'(aborted), 1);
        // Next burst is requested in the done cycle and must clear aborted.
        run_burst("after abort", 16'h0300, 1, 1, 1, -1, 5, fo, dof, nw);
        check_int("after abort words", nw, 2);
        @(negedge clk);
        @(negedge clk);

        // Asynchronous reset in the middle of CE_WAIT.
        start_addr = 16'h4444;
        burst_len = 4'd3;
        tce = 4'd5;
        toe = 4'd6;
        req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        check_int("pre-reset ce_n", int'(ce_n), 0);
        check_int("pre-reset busy", int'(busy), 1);
        n_rst = 1'b0;
        #1;
        check_int("mid reset ce_n", int'(ce_n), 1);
        check_int("mid reset busy", int'(busy), 0);
        check_int("mid reset flash_addr", int'(flash_addr), 0);
        check_int("mid reset rdata", int'(rdata), 0);
        @(negedge clk);
        check_int("mid reset no done", int'({done, rdata_valid}), 0);
        n_rst = 1'b1;
        @(negedge clk);
        run_burst("post reset", 16'h0100, 0, 5, 6, -1, -1, fo, dof, nw);
        check_int("post reset first", fo, 13);
        @(negedge clk);

        for (int r = 0; r < 20; r++) begin
            int bl, tv, ov, ab, last;
            bl = $urandom_range(0, 7);
            tv = $urandom_range(0, 6);
            ov = $urandom_range(0, 6);
            last = ((tv == 0) ? 1 : tv) + ((ov == 0) ? 1 : ov) + 2 +
                   bl * (((ov == 0) ? 1 : ov) + 1);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, last - 1) : -1;
            run_burst($sformatf("rand%0d", r), 16'($urandom), bl, tv, ov, ab,
                      ($urandom_range(0, 1) == 1) ? 1 : -1, fo, dof, nw);
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clk);
                @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flash_burst_reader.md
# flash_burst_reader

Parametrised successor to the single-word flash memory controller: fetches a burst of 1..2^BL_W consecutive words from an asynchronous parallel NOR flash using runtime-programmable CE-to-OE and OE-to-data delays. Sits between the weight/image loader and the external flash pins. Adds a req/busy/done handshake, page-mode burst reads with automatic address increment, an abort path, and active-low chip controls.

## Interface
- ADDR_W, 16, flash address width
- DATA_W, 16, flash data width
- CNT_W, 4, width of the delay fields and the wait counter
- BL_W, 4, width of burst_len
- TREC, 2, number of recovery cycles with ce_n/oe_n high after a burst (must be ≥1)
- clk  in  1  clock
- n_rst  in  1  reset n_rst, asynchronous, active-low
- req  in  1  start request; sampled only in IDLE
- abort  in  1  terminate the current burst
- start_addr  in  ADDR_W  first word address, latched on accept
- burst_len  in  BL_W  words minus 1, latched on accept
- tce  in  CNT_W  CE-low-to-OE-low delay in cycles, latched on accept; 0 behaves as 1
- toe  in  CNT_W  OE-low/address-change-to-data delay in cycles, latched on accept; 0 behaves as 1
- busy  out  1  high in every state except IDLE
- rdata  out  DATA_W  last captured word
- rdata_valid  out  1  one-cycle strobe per captured word
- done  out  1  one-cycle pulse at burst end
- aborted  out  1  set with done when the burst was aborted; cleared on next accept
- flash_addr  out  ADDR_W  address pins
- flash_data  in  DATA_W  data pins
- ce_n, oe_n, we_n  out  1  active-low chip enable, output enable, write enable (we_n constant 1)

## Operation
- States: IDLE, SETUP, CE_WAIT, OE_WAIT, CAPTURE, RECOVER.
- IDLE: ce_n=oe_n=1. When req=1, latch start_addr, burst_len, tce, toe; word counter ← burst_len; go to SETUP. While busy, req is ignored.
- SETUP (1 cycle): flash_addr ← latched address, ce_n=1, wait counter cleared → CE_WAIT.
- CE_WAIT: ce_n=0, oe_n=1, lasts max(tce,1) cycles → OE_WAIT.
- OE_WAIT: ce_n=0, oe_n=0, lasts max(toe,1) cycles → CAPTURE.
- CAPTURE (1 cycle): at the closing edge rdata ← flash_data and rdata_valid=1 the following cycle. If word counter = 0 → RECOVER; otherwise word counter −1, flash_addr +1 (mod 2^ADDR_W, wrapping to 0), wait counter cleared → OE_WAIT (ce_n/oe_n stay low: page mode).
- RECOVER: ce_n=oe_n=1 for TREC cycles → IDLE; done=1 in the first IDLE cycle.
- abort=1 in SETUP/CE_WAIT/OE_WAIT/CAPTURE: next state is RECOVER, no further rdata_valid (a CAPTURE coinciding with abort still delivers its word), and aborted=1 together with done. abort in RECOVER/IDLE is ignored.
- Wait counter: CNT_W bits, cleared on every state entry; compare against latched delay minus 1.

## Timing
- Reset values: ce_n=1, oe_n=1, we_n=1, flash_addr=0, rdata=0, rdata_valid=0, done=0, aborted=0, busy=0, state IDLE, counters 0.
- Reset mid-burst: all outputs return to reset values immediately and asynchronously; no done pulse.
- req sampled at edge E0 → first rdata_valid high in the cycle after edge E0+T+2, where T = max(tce,1)+max(toe,1).
- Successive words in a burst are max(toe,1)+1 cycles apart.
- done at edge (last CAPTURE edge)+TREC+1; req may be reasserted in the done cycle and is accepted.
- flash_addr changes only on SETUP entry and CAPTURE exit; stays stable otherwise.

## Structure
- Package flash_pkg: state enum typedef, default timing constants (TCE_DEF=5, TOE_DEF=6, TREC_DEF=2).
- Wait counter: one instance of the existing flex_counter (NUM_CNT_BITS=CNT_W, clear on state entry); word counter and address incrementer inline.

## Test plan
- Single word: burst_len=0, tce=5, toe=6, start_addr=0x0100, flash model returns 0xBEEF → ce_n falls at E2, oe_n falls at E7, rdata_valid/rdata=0xBEEF in the cycle after E13, done after E16.
- Burst of 4 from 0x0010, toe=3: rdata_valid every 4 cycles, flash_addr 0x10..0x13, ce_n low continuously from CE_WAIT to the last CAPTURE.
- Wrap-around: start_addr=0xFFFE, burst_len=3 → addresses FFFE, FFFF, 0000, 0001.
- tce=0, toe=0 → behaves as 1/1; first valid after E0+4.
- abort during the second OE_WAIT of a 4-word burst → exactly 1 rdata_valid, done+aborted, ce_n high next cycle; req during busy ignored.
- n_rst asserted mid-CE_WAIT → ce_n=1, busy=0 immediately; a new req after release runs normally.
